// File: rtl/cpu_dbg_pkg.sv
// Shared CPU debug package.
// Holds the trace capture state encoding and default channel geometry used by
// cpu_trace_buffer and the other CPU debug blocks.
package cpu_dbg_pkg;

  localparam int TRACE_DATA_W   = 32;
  localparam int TRACE_CHANNELS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH simple dual-port RAM.
// One synchronous write port and one registered read port, no reset on the
// array or the read register so the array can map onto block RAM.
// Ports:
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; rdata_o updates on the next rising edge
//   raddr_i  read address
//   rdata_o  registered read data
module trace_ram #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// On-chip pre/post-trigger trace capture for the single-cycle CPU.
// Samples CHANNELS words per capture_en cycle into a DEPTH-entry circular
// buffer. A trigger (channel-0 match or force_trig) starts a POST_TRIG-sample
// tail, after which the buffer freezes and is read back oldest-first through
// a 1-cycle-latency port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   arm                 clear the buffer and start a new capture
//   capture_en          sample qualifier
//   ch_data             packed channel words, channel k at [k*DATA_W +: DATA_W]
//   trig_value          compare value for channel 0
//   trig_match_en       enable the channel-0 compare
//   force_trig          unconditional trigger (still qualified by capture_en)
//   rd_req, rd_addr     read strobe and index relative to the oldest sample
//   rd_valid, rd_data, rd_err   read result, one cycle after rd_req
//   state, done         capture state (IDLE/ARMED/POST/DONE), DONE flag
//   sample_count        stored samples, saturating at DEPTH
//   trig_index          trigger sample index relative to the oldest sample
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W    = TRACE_DATA_W,
  parameter int CHANNELS  = TRACE_CHANNELS,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       capture_en,
  input  logic [CHANNELS*DATA_W-1:0] ch_data,
  input  logic [DATA_W-1:0]          trig_value,
  input  logic                       trig_match_en,
  input  logic                       force_trig,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_valid,
  output logic [CHANNELS*DATA_W-1:0] rd_data,
  output logic                       rd_err,
  output logic [1:0]                 state,
  output logic                       done,
  output logic [ADDR_W:0]            sample_count,
  output logic [ADDR_W-1:0]          trig_index
);

  localparam int               WORD_W    = CHANNELS * DATA_W;
  localparam logic [ADDR_W-1:0] POST_LIM  = ADDR_W'(POST_TRIG);
  // trig_index = count-1-POST_TRIG; taken mod DEPTH since the result always
  // lies in 0..DEPTH-1 and a saturated count reads as 0 in the low bits.
  localparam logic [ADDR_W-1:0] POST_PLUS1 = ADDR_W'(POST_TRIG + 1);
  localparam bit               NO_POST   = (POST_TRIG == 0);

  trace_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] trig_idx_q, trig_idx_d;
  logic              rd_valid_q;
  logic              rd_err_q;

  logic              hit;
  logic              full;
  logic              we;
  logic [ADDR_W-1:0] oldest;
  logic [ADDR_W-1:0] rd_phys;
  logic              rd_bad;
  logic [WORD_W-1:0] ram_rdata;

  assign full = cnt_q[ADDR_W];
  assign hit  = capture_en &
                ((trig_match_en & (ch_data[DATA_W-1:0] == trig_value)) | force_trig);

  // Next-state, pointer and counter logic; arm overrides everything.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    post_d     = post_q;
    trig_idx_d = trig_idx_q;
    we         = 1'b0;
    if (arm) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      cnt_d    = '0;
      post_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (capture_en) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!full) cnt_d = cnt_q + 1'b1;
            if (hit) begin
              post_d = '0;
              if (NO_POST) begin
                state_d    = DONE;
                trig_idx_d = cnt_d[ADDR_W-1:0] - POST_PLUS1;
              end else begin
                state_d = POST;
              end
            end
          end
        end
        POST: begin
          if (capture_en) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (!full) cnt_d = cnt_q + 1'b1;
            post_d = post_q + 1'b1;
            if (post_d == POST_LIM) begin
              state_d    = DONE;
              trig_idx_d = cnt_d[ADDR_W-1:0] - POST_PLUS1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      post_q     <= '0;
      trig_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      post_q     <= post_d;
      trig_idx_q <= trig_idx_d;
    end
  end

  // Read path: address is rebased on the oldest sample; the error flag is
  // registered alongside the RAM's own read register. An arm in the same
  // cycle as rd_req invalidates the read.
  assign oldest  = full ? wr_ptr_q : '0;
  assign rd_phys = oldest + rd_addr;
  assign rd_bad  = arm | (state_q != DONE) | ({1'b0, rd_addr} >= cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_err_q <= rd_bad;
    end
  end

  trace_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ch_data),
    .re_i    (rd_req),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  // RAM read register is unreset, so data is gated to zero unless a
  // good read result is being presented.
  assign rd_data      = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign rd_err       = rd_err_q;
  assign state        = state_q;
  assign done         = (state_q == DONE);
  assign sample_count = cnt_q;
  assign trig_index   = trig_idx_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          capture_en = 1'b0;
  logic [CH*DW-1:0] ch_data = '0;
  logic [DW-1:0] trig_value = '0;
  logic          trig_match_en = 1'b0;
  logic          force_trig = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          a_rd_valid, a_rd_err, a_done;
  logic [CH*DW-1:0] a_rd_data;
  logic [1:0]    a_state;
  logic [AW:0]   a_cnt;
  logic [AW-1:0] a_tidx;

  logic          b_rd_valid, b_rd_err, b_done;
  logic [CH*DW-1:0] b_rd_data;
  logic [1:0]    b_state;
  logic [AW:0]   b_cnt;
  logic [AW-1:0] b_tidx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DP), .POST_TRIG(3)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .capture_en(capture_en), .ch_data(ch_data),
    .trig_value(trig_value), .trig_match_en(trig_match_en), .force_trig(force_trig),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .rd_err(a_rd_err), .state(a_state), .done(a_done), .sample_count(a_cnt),
    .trig_index(a_tidx)
  );

  cpu_trace_buffer #(.DATA_W(DW), .CHANNELS(CH), .DEPTH(DP), .POST_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .capture_en(capture_en), .ch_data(ch_data),
    .trig_value(trig_value), .trig_match_en(trig_match_en), .force_trig(force_trig),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .rd_err(b_rd_err), .state(b_state), .done(b_done), .sample_count(b_cnt),
    .trig_index(b_tidx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One qualified/unqualified sample cycle; ch1 is the complement of ch0.
  task automatic step(input logic en, input logic [7:0] v, input logic frc);
    capture_en = en;
    ch_data    = {~v, v};
    force_trig = frc;
    @(posedge clk); #1;
    capture_en = 1'b0;
    force_trig = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_tidx", 32'(a_tidx), 32'd0);
    chk("rst_rvalid", 32'(a_rd_valid), 32'd0);
    chk("rst_rerr", 32'(a_rd_err), 32'd0);
    chk("rst_rdata", 32'(a_rd_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Full wrap, trigger on 20
    trig_match_en = 1'b1;
    trig_value    = 8'd20;
    do_arm();
    chk("t1_armed", 32'(a_state), 32'd1);
    for (int v = 0; v < 21; v++) step(1'b1, 8'(v), 1'b0);
    chk("t1_post", 32'(a_state), 32'd2);
    step(1'b1, 8'd21, 1'b0);
    step(1'b1, 8'd22, 1'b0);
    chk("t1_still_post", 32'(a_state), 32'd2);
    step(1'b1, 8'd23, 1'b0);
    chk("t1_done_state", 32'(a_state), 32'd3);
    chk("t1_done", 32'(a_done), 32'd1);
    chk("t1_cnt", 32'(a_cnt), 32'd8);
    chk("t1_tidx", 32'(a_tidx), 32'd4);
    step(1'b1, 8'd24, 1'b0);
    chk("t1_frozen_cnt", 32'(a_cnt), 32'd8);
    rd(3'd0);
    chk("t1_r0_valid", 32'(a_rd_valid), 32'd1);
    chk("t1_r0_err", 32'(a_rd_err), 32'd0);
    chk("t1_r0_data", 32'(a_rd_data), {16'd0, 8'hEF, 8'd16});
    // back-to-back reads
    rd_req = 1'b1; rd_addr = 3'd4;
    @(posedge clk); #1;
    chk("t1_r4_ch0", 32'(a_rd_data[7:0]), 32'd20);
    rd_addr = 3'd7;
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("t1_r7_ch0", 32'(a_rd_data[7:0]), 32'd23);
    chk("t1_r7_err", 32'(a_rd_err), 32'd0);
    @(posedge clk); #1;
    chk("t1_rvalid_drop", 32'(a_rd_valid), 32'd0);

    // 2. Early trigger on 2
    trig_value = 8'd2;
    do_arm();
    chk("t2_cnt_clear", 32'(a_cnt), 32'd0);
    for (int v = 0; v < 6; v++) step(1'b1, 8'(v), 1'b0);
    chk("t2_state", 32'(a_state), 32'd3);
    chk("t2_cnt", 32'(a_cnt), 32'd6);
    chk("t2_tidx", 32'(a_tidx), 32'd2);
    rd(3'd6);
    chk("t2_r6_valid", 32'(a_rd_valid), 32'd1);
    chk("t2_r6_err", 32'(a_rd_err), 32'd1);
    chk("t2_r6_data", 32'(a_rd_data), 32'd0);
    rd(3'd2);
    chk("t2_r2_err", 32'(a_rd_err), 32'd0);
    chk("t2_r2_ch0", 32'(a_rd_data[7:0]), 32'd2);

    // 4. arm coincident with a channel-0 match
    trig_value = 8'd5;
    arm = 1'b1; capture_en = 1'b1; ch_data = {~8'd5, 8'd5};
    @(posedge clk); #1;
    arm = 1'b0; capture_en = 1'b0;
    chk("t4_state", 32'(a_state), 32'd1);
    chk("t4_cnt", 32'(a_cnt), 32'd0);
    step(1'b1, 8'd5, 1'b0);
    chk("t4_trig", 32'(a_state), 32'd2);
    chk("t4_cnt1", 32'(a_cnt), 32'd1);
    step(1'b1, 8'd6, 1'b0);
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd8, 1'b0);
    chk("t4_done", 32'(a_state), 32'd3);
    chk("t4_tidx", 32'(a_tidx), 32'd0);
    rd(3'd0);
    chk("t4_r0_ch0", 32'(a_rd_data[7:0]), 32'd5);

    // arm with a read in flight: read reports error
    trig_value = 8'd1;
    rd_req = 1'b1; rd_addr = 3'd0; arm = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0; arm = 1'b0;
    chk("t4_arm_rd_err", 32'(a_rd_err), 32'd1);
    chk("t4_arm_rd_data", 32'(a_rd_data), 32'd0);

    // 5. rst mid-POST
    step(1'b1, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd2, 1'b0);
    chk("t5_post", 32'(a_state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_state", 32'(a_state), 32'd0);
    chk("t5_async_done", 32'(a_done), 32'd0);
    chk("t5_async_cnt", 32'(a_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd(3'd0);
    chk("t5_rd_err", 32'(a_rd_err), 32'd1);
    chk("t5_rd_data", 32'(a_rd_data), 32'd0);
    step(1'b1, 8'd1, 1'b0);
    chk("t5_idle_state", 32'(a_state), 32'd0);
    chk("t5_idle_cnt", 32'(a_cnt), 32'd0);

    // 3. Qualifier gaps with force_trig
    trig_match_en = 1'b0;
    do_arm();
    step(1'b1, 8'd10, 1'b0);
    step(1'b0, 8'd11, 1'b1);
    chk("t3_no_trig", 32'(a_state), 32'd1);
    chk("t3_cnt_gap", 32'(a_cnt), 32'd1);
    step(1'b1, 8'd12, 1'b0);
    step(1'b1, 8'd13, 1'b1);
    chk("t3_trig", 32'(a_state), 32'd2);
    chk("t3_cnt3", 32'(a_cnt), 32'd3);
    step(1'b0, 8'd14, 1'b0);
    step(1'b1, 8'd15, 1'b0);
    step(1'b0, 8'd16, 1'b1);
    step(1'b1, 8'd17, 1'b0);
    chk("t3_still_post", 32'(a_state), 32'd2);
    chk("t3_cnt5", 32'(a_cnt), 32'd5);
    step(1'b0, 8'd18, 1'b0);
    step(1'b1, 8'd19, 1'b0);
    chk("t3_done", 32'(a_state), 32'd3);
    chk("t3_cnt6", 32'(a_cnt), 32'd6);
    chk("t3_tidx", 32'(a_tidx), 32'd2);
    rd(3'd2);
    chk("t3_r2_ch0", 32'(a_rd_data[7:0]), 32'd13);
    rd(3'd5);
    chk("t3_r5_word", 32'(a_rd_data), {16'd0, 8'hEC, 8'd19});

    // 6. POST_TRIG=0 instance, hit on sample 9
    trig_match_en = 1'b1;
    trig_value    = 8'd9;
    do_arm();
    for (int v = 0; v < 9; v++) step(1'b1, 8'(v), 1'b0);
    chk("t6_armed", 32'(b_state), 32'd1);
    step(1'b1, 8'd9, 1'b0);
    chk("t6_done", 32'(b_state), 32'd3);
    chk("t6_done_flag", 32'(b_done), 32'd1);
    chk("t6_cnt", 32'(b_cnt), 32'd8);
    chk("t6_tidx", 32'(b_tidx), 32'd7);
    rd(3'd7);
    chk("t6_r7_err", 32'(b_rd_err), 32'd0);
    chk("t6_r7_ch0", 32'(b_rd_data[7:0]), 32'd9);
    rd(3'd0);
    chk("t6_r0_ch0", 32'(b_rd_data[7:0]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
